// File: rtl/flash_responder.sv
// flash_responder: oversampled SPI/QSPI flash read responder serving bytes from a synchronous ROM port
module flash_responder #(
  parameter int ADDR_BITS = 24,
  parameter int QUAD_DUMMY_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flash_clk,
  input  logic                 flash_csn,
  input  logic [3:0]           flash_in_en,
  input  logic [3:0]           flash_in,
  output logic [3:0]           flash_out,
  output logic [3:0]           flash_out_en,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_read,
  input  logic [7:0]           rom_data
);
  typedef enum logic [3:0] {IDLE, CMD, ADDR_SPI, ADDR_QUAD, MODE, DUMMY, DATA_SPI, DATA_QUAD, IGNORE} state_t;
  state_t state, state_n;
  logic [2:0] sck_s;
  logic [1:0] csn_s;
  logic [3:0] in_s1, in_s2, oe;
  logic [23:0] acc, acc_n;
  logic [4:0] cnt, lim;
  logic [7:0] sh;
  logic cont, rd_d, rise, fall, last, quad;
  assign rise = sck_s[1] & ~sck_s[2];
  assign fall = ~sck_s[1] & sck_s[2];
  assign quad = state == ADDR_QUAD || state == MODE;
  assign acc_n = quad ? {acc[19:0], in_s2} : {acc[22:0], in_s2[0]};
  assign flash_out_en = csn_s[1] ? 4'b0000 : oe;
  always_comb begin
    lim = state == CMD || state == DATA_SPI ? 5'd7 :
          state == ADDR_SPI ? 5'd23 :
          state == ADDR_QUAD ? 5'd5 :
          state == DUMMY ? 5'(QUAD_DUMMY_CYCLES - 1) : 5'd1;
    last = rise && cnt == lim;
    state_n = state;
    if (csn_s[1]) state_n = IDLE;
    else if (state == IDLE) state_n = cont ? ADDR_QUAD : CMD;
    else if (last)
      case (state)
        CMD:       state_n = acc_n[7:0] == 8'h03 ? ADDR_SPI : acc_n[7:0] == 8'hEB ? ADDR_QUAD : IGNORE;
        ADDR_SPI:  state_n = DATA_SPI;
        ADDR_QUAD: state_n = MODE;
        MODE:      state_n = QUAD_DUMMY_CYCLES == 0 ? DATA_QUAD : DUMMY;
        DUMMY:     state_n = DATA_QUAD;
        default:   state_n = state;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_s <= '0;
      csn_s <= '1;
      in_s1 <= '0;
      in_s2 <= '0;
      acc <= '0;
      cnt <= '0;
      sh <= '0;
      oe <= '0;
      flash_out <= '0;
      rom_addr <= '0;
      rom_read <= 1'b0;
      rd_d <= 1'b0;
      cont <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], flash_clk};
      csn_s <= {csn_s[0], flash_csn};
      in_s1 <= flash_in;
      in_s2 <= in_s1;
      rd_d <= rom_read;
      // prefetch on entering a data phase and on completing every data byte
      rom_read <= last && (state_n == DATA_SPI || state_n == DATA_QUAD);
      if (rd_d) sh <= rom_data;
      if (csn_s[1]) begin
        cnt <= '0;
        oe <= '0;
        flash_out <= '0;
      end else begin
        if (rise) begin
          acc <= acc_n;
          cnt <= last ? 5'd0 : cnt + 5'd1;
        end
        if (last && (state == ADDR_SPI || state == ADDR_QUAD)) rom_addr <= acc_n[ADDR_BITS-1:0];
        if (last && (state == DATA_SPI || state == DATA_QUAD)) rom_addr <= rom_addr + 1'b1;
        if (last && state == MODE) cont <= acc_n[5:4] == 2'b10;
        if (last && state == CMD && acc_n[7:0] == 8'hFF) cont <= 1'b0;
        if (fall) begin
          oe <= state == DATA_SPI ? 4'b0010 : state == DATA_QUAD ? 4'b1111 : 4'b0000;
          flash_out <= state == DATA_SPI ? {2'b00, sh[7], 1'b0} : state == DATA_QUAD ? sh[7:4] : 4'b0000;
          sh <= state == DATA_QUAD ? sh << 4 : sh << 1;
        end
      end
    end
  assert property (@(posedge clk) disable iff (!reset_n) (flash_in_en & flash_out_en) == 4'b0000);
endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder: randomized flash transactions checked by data and ROM-address scoreboards
module tb_flash_responder;
  logic clk = 0, reset_n = 0, flash_clk = 0, flash_csn = 1;
  logic [3:0] flash_in_en = 0, flash_in = 0, flash_out, flash_out_en;
  logic [23:0] rom_addr;
  logic rom_read;
  logic [7:0] rom_data = 0;
  int checks = 0, errors = 0;
  logic [7:0] exp_bytes[$];
  logic [23:0] exp_addrs[$];
  bit model_cont = 0;
  logic [7:0] mbyte;
  int mbits = 0;
  always #5 clk = ~clk;
  flash_responder #(.ADDR_BITS(24), .QUAD_DUMMY_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .flash_clk(flash_clk), .flash_csn(flash_csn),
    .flash_in_en(flash_in_en), .flash_in(flash_in), .flash_out(flash_out),
    .flash_out_en(flash_out_en), .rom_addr(rom_addr), .rom_read(rom_read), .rom_data(rom_data)
  );
  always @(posedge clk) if (rom_read) rom_data <= rom_addr[7:0];
  function automatic logic [7:0] rom_fn(input logic [23:0] a);
    return a[7:0];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // controller-side view: sample IO on every SCK rise while the responder drives
  always @(posedge flash_clk or posedge flash_csn or negedge reset_n) begin
    if (flash_csn || !reset_n) mbits = 0;
    else if (flash_out_en == 4'b0010) begin
      mbyte = {mbyte[6:0], flash_out[1]};
      mbits += 1;
    end else if (flash_out_en == 4'b1111) begin
      mbyte = {mbyte[3:0], flash_out};
      mbits += 4;
    end
    if (mbits == 8) begin
      mbits = 0;
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data: got 0x%0h, expected no byte", mbyte);
      end else chk("data", mbyte, exp_bytes.pop_front());
    end
  end
  always @(negedge clk) if (reset_n && rom_read) begin
    if (exp_addrs.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rom_addr: got 0x%0h, expected no read", rom_addr);
    end else chk("rom_addr", rom_addr, exp_addrs.pop_front());
  end
  task automatic sck_bit(input logic [3:0] v, input logic [3:0] exp_oe, input string name);
    flash_in = v;
    repeat (5) @(negedge clk);
    chk(name, flash_out_en, exp_oe);
    flash_clk = 1;
    repeat (5) @(negedge clk);
    flash_clk = 0;
  endtask
  task automatic csn_start;
    @(negedge clk);
    flash_csn = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic csn_end;
    flash_csn = 1;
    flash_in_en = 0;
    repeat (3) @(negedge clk);
    chk("oe_after_csn", flash_out_en, 0);
    repeat (5) @(negedge clk);
  endtask
  task automatic send_ser(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sck_bit({3'b000, v[i]}, 4'b0000, "oe_spi_hdr");
  endtask
  task automatic send_nib(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sck_bit(v[4*i+:4], 4'b0000, "oe_quad_hdr");
  endtask
  task automatic push_read(input logic [23:0] a, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_bytes.push_back(rom_fn(a + 24'(i)));
    for (int i = 0; i <= nbytes; i++) exp_addrs.push_back(a + 24'(i));
  endtask
  task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] a, input int nbytes, input int extra);
    bit rd;
    rd = cmd == 8'h03;
    if (rd) push_read(a, nbytes);
    if (cmd == 8'hFF) model_cont = 0;
    csn_start;
    flash_in_en = 4'b0001;
    send_ser(cmd, 8);
    send_ser(a, 24);
    flash_in_en = 0;
    for (int i = 0; i < nbytes * 8 + extra; i++) sck_bit(4'($urandom), rd ? 4'b0010 : 4'b0000, "oe_spi_data");
    csn_end;
  endtask
  task automatic quad_txn(input logic [23:0] a, input logic [7:0] mode, input int nbytes);
    bit with_cmd;
    with_cmd = !model_cont;
    push_read(a, nbytes);
    model_cont = mode[5:4] == 2'b10;
    csn_start;
    if (with_cmd) begin
      flash_in_en = 4'b0001;
      send_ser(8'hEB, 8);
    end
    flash_in_en = 4'b1111;
    send_nib(a, 6);
    send_nib(mode, 2);
    flash_in_en = 0;
    repeat (4) sck_bit(4'($urandom), 4'b0000, "oe_dummy");
    for (int i = 0; i < nbytes * 2; i++) sck_bit(4'($urandom), 4'b1111, "oe_quad_data");
    csn_end;
  endtask
  // continuous-mode read cut short by reset while the first nibble is out
  task automatic reset_mid(input logic [23:0] a);
    exp_addrs.push_back(a);
    csn_start;
    flash_in_en = 4'b1111;
    send_nib(a, 6);
    send_nib(8'hA0, 2);
    flash_in_en = 0;
    repeat (4) sck_bit(4'($urandom), 4'b0000, "oe_dummy");
    sck_bit(4'($urandom), 4'b1111, "oe_quad_data");
    #2 reset_n = 0;
    #1;
    chk("async_rst_oe", flash_out_en, 0);
    chk("async_rst_out", flash_out, 0);
    chk("async_rst_addr", rom_addr, 0);
    chk("async_rst_read", rom_read, 0);
    model_cont = 0;
    flash_csn = 1;
    repeat (4) @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    logic [7:0] unk [4];
    logic [23:0] a;
    unk = '{8'h9F, 8'hAB, 8'hFF, 8'h05};
    repeat (40) begin
      @(negedge clk);
      flash_clk = 1'($urandom);
      flash_csn = 1'($urandom);
      flash_in = 4'($urandom);
      flash_in_en = 4'($urandom);
      chk("reset_oe", flash_out_en, 0);
      chk("reset_out", flash_out, 0);
      chk("reset_read", rom_read, 0);
      chk("reset_addr", rom_addr, 0);
    end
    flash_clk = 0;
    flash_csn = 1;
    flash_in = 0;
    flash_in_en = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    spi_txn(8'h03, 24'h000100, 2, 0);
    quad_txn(24'h001234, 8'hA0, 2);
    quad_txn(24'h000010, 8'hA0, 1);
    quad_txn(24'h000040, 8'hFF, 1);
    spi_txn(8'h03, 24'h000080, 1, 0);
    spi_txn(8'h9F, 24'h000123, 2, 0);
    spi_txn(8'h03, 24'h000200, 1, 0);
    spi_txn(8'h03, 24'h000300, 1, 3);
    spi_txn(8'h03, 24'h000020, 1, 0);
    spi_txn(8'h03, 24'hFFFFFF, 2, 0);
    quad_txn(24'hFFFFFE, 8'h20, 3);
    reset_mid(24'h000555);
    spi_txn(8'h03, 24'h000777, 1, 0);
    for (int n = 0; n < 12; n++) begin
      a = $urandom_range(0, 1) ? 24'hFFFFFF - 24'($urandom_range(0, 2)) : 24'($urandom);
      if (model_cont) quad_txn(a, 8'($urandom), $urandom_range(1, 3));
      else
        case ($urandom_range(0, 3))
          0: spi_txn(8'h03, a, $urandom_range(1, 3), 0);
          1: quad_txn(a, 8'($urandom), $urandom_range(1, 3));
          2: spi_txn(unk[$urandom_range(0, 3)], a, 1, 0);
          default: spi_txn(8'h03, a, $urandom_range(0, 2), $urandom_range(1, 7));
        endcase
    end
    repeat (20) @(negedge clk);
    chk("exp_bytes_left", exp_bytes.size(), 0);
    chk("exp_addrs_left", exp_addrs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_responder.md
Name: flash_responder

Overview:
- Synthesizable SPI/QSPI flash device model: the responder end of the flash interface that the ics32 flash controller and bootloader drive.
- Replaces the C++ flash blackbox in sim/FPGA self-test builds.
- Oversamples the flash pins on the system clock, decodes read commands and serves bytes from an external synchronous ROM port.

Parameters:
ADDR_BITS, 24, flash byte-address width; address wraps modulo 2^ADDR_BITS
QUAD_DUMMY_CYCLES, 4, flash_clk cycles between mode byte and first data nibble for 0xEB

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
flash_clk  input  1  SCK from controller, sampled by clk
flash_csn  input  1  chip select, active low
flash_in_en  input  4  controller IO output enables (informational; drive-contention check only)
flash_in  input  4  IO[3:0] driven by controller
flash_out  output  4  IO[3:0] driven by this block
flash_out_en  output  4  per-line output enable
rom_addr  output  ADDR_BITS  byte address to backing ROM
rom_read  output  1  one-cycle read strobe
rom_data  input  8  ROM byte, valid exactly 1 clk after rom_read

Behaviour:
- Reset: flash_out=0, flash_out_en=0, rom_read=0, rom_addr=0, state=IDLE, continuous-mode flag=0.
- Sampling: flash_clk, flash_csn, flash_in pass through 2 register stages. Rise/fall are detected from stage2 vs stage3 of flash_clk. flash_in is taken from the same stage as the detected edge.
- Timing requirement: flash_clk high and low each >=3 clk.
- Inputs are captured on a detected rise. Outputs update on the clk after a detected fall.
- Sampled csn high:
  - state->IDLE next clk; flash_out_en=0 same clk.
  - Any partial command, address or byte is discarded. The continuous flag is kept.
- On csn falling:
  - state->ADDR_QUAD if the continuous flag=1.
  - state->CMD otherwise.
- States and transitions:
  - CMD: 8 rises, IO0, MSB first.
    - 0x03->ADDR_SPI.
    - 0xEB->ADDR_QUAD.
    - 0xAB (wake)->IGNORE.
    - 0xFF->clear continuous flag, IGNORE.
    - Other->IGNORE.
  - ADDR_SPI: 24 rises on IO0, MSB first. Low ADDR_BITS are kept, upper bits are dropped. Then DATA_SPI.
  - ADDR_QUAD: 6 rises, nibble IO[3:0], high nibble first. Then MODE.
  - MODE: 2 rises. Continuous flag is set when mode[5:4]==2'b10 and cleared otherwise. Then DUMMY.
  - DUMMY: QUAD_DUMMY_CYCLES rises, then DATA_QUAD. If QUAD_DUMMY_CYCLES=0, go directly to DATA_QUAD.
  - DATA_SPI:
    - flash_out_en=4'b0010.
    - Byte shifted on IO1, MSB first, one bit per fall.
    - The first bit is driven on the fall following the last address rise.
  - DATA_QUAD:
    - flash_out_en=4'b1111.
    - High nibble, then low nibble, one per fall.
  - IGNORE: flash_out_en=0 until csn high.
- ROM prefetch:
  - rom_read is pulsed 1 clk after the rise that completes the address (SPI) or the last dummy cycle (quad), with rom_addr=address.
  - rom_data is latched into the shift register the next clk.
  - Each subsequent byte: rom_addr increments, and rom_read pulses on the rise completing the current byte's last bit/nibble. The new byte is loaded before the next fall.
- Address increments mod 2^ADDR_BITS (0xFFFFFF->0x000000 at 24 bits).
- Contention: any bit set in both flash_in_en and flash_out_en is a sim assertion error only, with no RTL behaviour.
- reset_n asserted mid-transaction: all state and outputs return to reset values immediately (async), including the continuous flag.

Test Plan:
- Reset: hold reset_n=0 with toggling pins -> flash_out_en=0, flash_out=0, rom_read=0 throughout.
- SPI read: csn low, cmd 0x03, addr 0x000100, 16 more clocks; ROM[n]=n[7:0] -> IO1 yields 0x00,0x01; rom_addr sequence 0x100,0x101,0x102; out_en=4'b0010 only in data phase.
- Quad continuous: cmd 0xEB, addr 0x001234, mode 0xA0, 4 dummy, 4 nibbles -> nibbles 3,4,3,5. Next csn cycle with no cmd, addr 0x000010, mode 0xA0 -> data 0x10 served. A further cycle with mode 0xFF, then a cycle with 0x03 as the command -> SPI read works.
- Unknown cmd 0x9F -> out_en stays 0, no rom_read until csn high. The next transaction decodes a command normally.
- Abort: csn high after 3 bits of a data byte -> out_en=0 within 3 clk. A new 0x03 read from 0x000020 returns ROM[0x20] from bit 0.
- Wrap: 0x03 at 0xFFFFFF for 2 bytes -> rom_addr 0xFFFFFF then 0x000000; data ROM[0xFFFFFF], ROM[0].
